// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {StBoot, StRun} fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries with synchronous flush and a
// combinationally readable head.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  fetch_entry_t  wdata,
  output fetch_entry_t  head,
  output logic [PtrW:0] count,
  output logic          empty,
  output logic          full
);

  localparam logic [PtrW-1:0] PtrInc = PtrW'(1);
  localparam logic [PtrW:0] CntInc = (PtrW + 1)'(1);
  localparam logic [PtrW:0] CntFull = (PtrW + 1)'(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PtrW:0]   count_q;
  logic            do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntFull);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrInc;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrInc;
      if (do_push && !do_pop) begin
        count_q <= count_q + CntInc;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CntInc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: credit-limited req/gnt/rvalid fetching into a
// prefetch FIFO, with flush-and-restart on redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     DEPTH           = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc
);

  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] PcStep = XLEN'(4);
  localparam logic [XLEN-1:0] AlignMask = ~XLEN'(3);
  localparam logic [OutW-1:0] OutOne = OutW'(1);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [XLEN-1:0] last_pc_q, last_pc_d;
  logic [OutW-1:0] outstanding_q, outstanding_d;
  logic [OutW-1:0] discard_q, discard_d;

  logic [CntW-1:0] fifo_count;
  logic            fifo_empty, fifo_full, fifo_push, fifo_pop;
  fetch_entry_t    fifo_head, fifo_wdata;

  logic            grant, resp;
  logic [XLEN-1:0] redirect_pc_aligned;
  logic [31:0]     credits_used;

  assign redirect_pc_aligned = redirect_pc & AlignMask;
  // Buffered plus in-flight words must fit the FIFO, so responses never overflow it.
  assign credits_used = 32'(fifo_count) + 32'(outstanding_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:  state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StBoot;
    endcase
  end

  always_comb begin
    imem_req = (state_q == StRun) && !redirect_valid &&
               (32'(outstanding_q) < MAX_OUTSTANDING) && (credits_used < DEPTH);
    imem_addr = fetch_pc_q;
    grant     = imem_req && imem_gnt;
    resp      = imem_rvalid && (outstanding_q != '0);

    outstanding_d = outstanding_q;
    if (grant && !resp) begin
      outstanding_d = outstanding_q + OutOne;
    end else if (resp && !grant) begin
      outstanding_d = outstanding_q - OutOne;
    end

    // Every request still in flight after a redirect belongs to the old path.
    discard_d = discard_q;
    if (redirect_valid) begin
      discard_d = outstanding_d;
    end else if (resp && (discard_q != '0)) begin
      discard_d = discard_q - OutOne;
    end

    fifo_push  = resp && (discard_q == '0) && !redirect_valid && !fifo_full;
    fifo_pop   = !fifo_empty && out_ready && !redirect_valid;
    fifo_wdata = '{pc: resp_pc_q, instr: imem_rdata};

    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc_aligned;
      resp_pc_d  = redirect_pc_aligned;
    end else begin
      if (grant)     fetch_pc_d = fetch_pc_q + PcStep;
      if (fifo_push) resp_pc_d  = resp_pc_q + PcStep;
    end

    last_pc_d = fifo_pop ? fifo_head.pc : last_pc_q;

    out_valid = !fifo_empty;
    out_instr = fifo_empty ? NOP_INSTR : fifo_head.instr;
    out_pc    = fifo_empty ? last_pc_q : fifo_head.pc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StBoot;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      last_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      last_pc_q     <= last_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(redirect_valid),
    .push (fifo_push),
    .pop  (fifo_pop),
    .wdata(fifo_wdata),
    .head (fifo_head),
    .count(fifo_count),
    .empty(fifo_empty),
    .full (fifo_full)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: randomized memory/core traffic checked every cycle
// against a queue-based model, plus directed cases with literal expectations.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  always #5 clk = ~clk;

  fetch_unit #(
    .DEPTH(DEPTH),
    .MAX_OUTSTANDING(MAXO),
    .RESET_PC(RST_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return ~a ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  // Reference model: in-flight requests tagged stale on redirect; FIFO as a queue.
  typedef struct { logic [31:0] addr; bit stale; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  req_t        m_infl[$];
  ent_t        m_fifo[$];
  logic [31:0] m_fetch_pc;
  bit          m_run;

  always @(negedge clk) begin : compare
    bit   exp_req, exp_valid, have_push;
    req_t r;
    ent_t e;
    if (!rst) begin
      m_run = 0;
      m_fetch_pc = RST_PC;
      m_infl.delete();
      m_fifo.delete();
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, RST_PC);
      chk("rst_valid", out_valid, 0);
      chk("rst_instr", out_instr, NOP_INSTR);
      chk("rst_pc", out_pc, RST_PC);
    end else begin
      exp_req = m_run && !redirect_valid && (m_infl.size() < MAXO) &&
                (m_fifo.size() + m_infl.size() < DEPTH);
      exp_valid = (m_fifo.size() > 0);
      chk("imem_req", imem_req, exp_req);
      chk("imem_addr", imem_addr, m_fetch_pc);
      chk("out_valid", out_valid, exp_valid);
      if (exp_valid) begin
        chk("out_pc", out_pc, m_fifo[0].pc);
        chk("out_instr", out_instr, m_fifo[0].instr);
      end else begin
        chk("out_instr_nop", out_instr, NOP_INSTR);
      end
      have_push = 0;
      if (imem_rvalid && m_infl.size() > 0) begin
        r = m_infl.pop_front();
        if (!r.stale) begin
          have_push = 1;
          e.pc = r.addr;
          e.instr = memfn(r.addr);
        end
      end
      if (exp_req && imem_gnt) begin
        m_infl.push_back('{m_fetch_pc, 1'b0});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
      if (redirect_valid) begin
        m_fifo.delete();
        foreach (m_infl[i]) m_infl[i].stale = 1;
        m_fetch_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (exp_valid && out_ready) void'(m_fifo.pop_front());
        if (have_push) m_fifo.push_back(e);
      end
      m_run = 1;
    end
  end

  // Memory: in-order responses with per-request latency.
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pend[$];
  bit rnd_mode = 0;
  bit force_rv = 0;
  int p_ready = 70, p_gnt = 70, p_redir = 4;
  int lat_min = 1, lat_max = 1;

  task automatic drive_inputs();
    pend_t p;
    if (rnd_mode) begin
      out_ready = ($urandom_range(99) < p_ready);
      imem_gnt = ($urandom_range(99) < p_gnt);
      redirect_valid = ($urandom_range(99) < p_redir);
      redirect_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15)) : $urandom;
    end
    imem_rvalid = 1'b0;
    imem_rdata = $urandom;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata = memfn(p.addr);
    end else if (force_rv) begin
      imem_rvalid = 1'b1;
      force_rv = 0;
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      drive_inputs();
      @(negedge clk);
      if (rst && imem_req && imem_gnt)
        pend.push_back('{imem_addr, cyc + int'($urandom_range(lat_max, lat_min))});
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(2);
    for (int i = 0; i < 20 && pend.size() > 0; i++) step(1);
    rst = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 30 && !out_valid; i++) step(1);
    chk(name, out_valid, 1);
  endtask

  task automatic zero_wait(input bit ready);
    rnd_mode = 0;
    redirect_valid = 0;
    out_ready = ready;
    imem_gnt = 1;
    lat_min = 1;
    lat_max = 1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;

    // Zero-wait memory, core always ready.
    zero_wait(1);
    do_reset();
    step(2);
    chk("t1_not_yet_valid", out_valid, 0);
    step(1);
    chk("t1_valid_cycle3", out_valid, 1);
    chk("t1_pc0", out_pc, 32'h0);
    chk("t1_instr0", out_instr, 32'hEDCB_A987);
    step(1);
    chk("t1_pc4", out_pc, 32'h4);
    chk("t1_instr4", out_instr, 32'hEDCB_A983);
    step(1);
    chk("t1_pc8", out_pc, 32'h8);
    chk("t1_instr8", out_instr, 32'hEDCB_A98F);

    // Core stalled: FIFO fills to DEPTH, fetching stops, then drains in order.
    zero_wait(0);
    do_reset();
    step(10);
    chk("t2_req_off", imem_req, 0);
    chk("t2_valid", out_valid, 1);
    chk("t2_next_addr", imem_addr, 32'h10);
    out_ready = 1;
    chk("t2_pop0", out_pc, 32'h0);
    chk("t2_req_held", imem_req, 0);
    step(1);
    chk("t2_pop4", out_pc, 32'h4);
    chk("t2_req_resume", imem_req, 1);
    chk("t2_addr_resume", imem_addr, 32'h10);
    step(1);
    chk("t2_pop8", out_pc, 32'h8);
    step(1);
    chk("t2_popc", out_pc, 32'hC);
    step(1);
    chk("t2_pc10", out_pc, 32'h10);
    chk("t2_instr10", out_instr, 32'hEDCB_A997);

    // Three-cycle memory, redirect with two requests in flight.
    zero_wait(1);
    lat_min = 3;
    lat_max = 3;
    do_reset();
    for (int i = 0; i < 20 && m_infl.size() != 2; i++) step(1);
    if (m_infl.size() != 2) fail_timeout("t3_two_inflight");
    redirect_valid = 1;
    redirect_pc = 32'h100;
    step(1);
    redirect_valid = 0;
    chk("t3_flushed", out_valid, 0);
    chk("t3_addr", imem_addr, 32'h100);
    wait_valid("t3_wait");
    chk("t3_pc", out_pc, 32'h100);
    chk("t3_instr", out_instr, 32'hEDCB_A887);

    // Redirect to an unaligned PC coincident with a response and a pop.
    zero_wait(1);
    do_reset();
    step(6);
    redirect_valid = 1;
    redirect_pc = 32'h203;
    step(1);
    redirect_valid = 0;
    chk("t4_flushed", out_valid, 0);
    chk("t4_addr", imem_addr, 32'h200);
    wait_valid("t4_wait");
    chk("t4_pc", out_pc, 32'h200);
    chk("t4_instr", out_instr, 32'hEDCB_AB87);

    // Address wrap at the top of the address space.
    redirect_valid = 1;
    redirect_pc = 32'hFFFF_FFFC;
    step(1);
    redirect_valid = 0;
    chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    step(1);
    chk("t5_addr_wrap", imem_addr, 32'h0);
    wait_valid("t5_wait");
    chk("t5_pc_top", out_pc, 32'hFFFF_FFFC);
    chk("t5_instr_top", out_instr, 32'h1234_567B);
    step(1);
    chk("t5_pc_wrap", out_pc, 32'h0);

    // Asynchronous reset with requests in flight and entries buffered.
    zero_wait(0);
    lat_min = 3;
    lat_max = 3;
    do_reset();
    for (int i = 0; i < 30 && !(m_infl.size() >= 1 && m_fifo.size() >= 2); i++) step(1);
    if (!(m_infl.size() >= 1 && m_fifo.size() >= 2)) fail_timeout("t6_fill");
    #2;
    rst = 1'b0;
    #1;
    chk("t6_async_req", imem_req, 0);
    chk("t6_async_addr", imem_addr, RST_PC);
    chk("t6_async_valid", out_valid, 0);
    chk("t6_async_instr", out_instr, NOP_INSTR);
    chk("t6_async_pc", out_pc, RST_PC);
    lat_min = 1;
    lat_max = 1;
    out_ready = 1;
    do_reset();
    force_rv = 1;
    wait_valid("t6_wait");
    chk("t6_first_pc", out_pc, RST_PC);
    chk("t6_first_instr", out_instr, 32'hEDCB_A987);

    // Randomized traffic checked by the per-cycle model.
    rnd_mode = 1;
    lat_min = 1;
    lat_max = 4;
    p_ready = 70;
    p_gnt = 70;
    p_redir = 4;
    step(3000);
    p_ready = 100;
    p_gnt = 100;
    lat_max = 1;
    p_redir = 2;
    step(500);
    p_ready = 30;
    p_gnt = 90;
    lat_max = 3;
    step(1000);

    zero_wait(1);
    step(10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
